// File: rtl/reaction_pkg.sv
// Shared state encoding and constants for the reaction-time tester.
// Imported by the sequencer top and its millisecond prescaler.
package reaction_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DELAY   = 3'd1,
    ST_MEASURE = 3'd2,
    ST_DONE    = 3'd3,
    ST_FOUL    = 3'd4
  } state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 of a right-shifting register map to bit positions 0,2,3,5.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  localparam int DEFAULT_TICK_DIV = 100000;

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: counts 0..TICK_DIV-1 and flags the last count.
// A synchronous clear restarts the count so the first tick lands TICK_DIV cycles later.
module ms_tick_gen
  import reaction_pkg::*;
#(
  parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
  input  logic sysclk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/reaction_test_controller.sv
// Reaction-test sequencer: randomised foreperiod, GO indicator, millisecond timing,
// false-start and timeout detection, with registered status for display logic.
module reaction_test_controller
  import reaction_pkg::*;
#(
  parameter int TICK_DIV     = DEFAULT_TICK_DIV,
  parameter int MIN_DELAY_MS = 1000,
  parameter int RAND_BITS    = 10,
  parameter int MAX_RT_MS    = 9999,
  parameter int RT_W         = 14
) (
  input  logic            sysclk,
  input  logic            reset,
  input  logic            start_btn,
  input  logic            react_btn,
  input  logic            abort,
  output logic            led_go,
  output logic            busy,
  output logic [RT_W-1:0] result_ms,
  output logic            result_valid,
  output logic            false_start,
  output logic            timeout,
  output logic [2:0]      state_o
);

  localparam logic [15:0]     RAND_MASK = 16'((32'd1 << RAND_BITS) - 32'd1);
  localparam logic [RT_W-1:0] MIN_DELAY = RT_W'(MIN_DELAY_MS);
  localparam logic [RT_W-1:0] MAX_RT    = RT_W'(MAX_RT_MS);

  state_e          state_q, state_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic [RT_W-1:0] ms_cnt_q, ms_cnt_d;
  logic [RT_W-1:0] delay_target_q, delay_target_d;
  logic [RT_W-1:0] result_ms_q, result_ms_d;
  logic            result_valid_q, result_valid_d;
  logic            timeout_q, timeout_d;
  logic            false_start_q, false_start_d;
  logic            led_go_q, led_go_d;
  logic            busy_q, busy_d;
  logic            tick;
  logic            tick_clr;
  logic [RT_W-1:0] ms_next;
  logic [RT_W-1:0] new_target;

  ms_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .sysclk(sysclk),
    .reset (reset),
    .clr   (tick_clr),
    .tick  (tick)
  );

  assign lfsr_d     = {^(lfsr_q & LFSR_TAPS), lfsr_q[15:1]};
  assign ms_next    = ms_cnt_q + RT_W'(1);
  assign new_target = MIN_DELAY + RT_W'(lfsr_q & RAND_MASK);

  always_comb begin
    state_d        = state_q;
    ms_cnt_d       = ms_cnt_q;
    delay_target_d = delay_target_q;
    result_ms_d    = result_ms_q;
    result_valid_d = result_valid_q;
    timeout_d      = timeout_q;
    false_start_d  = false_start_q;
    tick_clr       = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE, ST_FOUL: begin
        if (start_btn) begin
          state_d        = ST_DELAY;
          ms_cnt_d       = '0;
          delay_target_d = new_target;
          result_ms_d    = '0;
          result_valid_d = 1'b0;
          timeout_d      = 1'b0;
          false_start_d  = 1'b0;
          tick_clr       = 1'b1;
        end
      end
      // A press before GO is a foul even on the tick that would have ended the wait.
      ST_DELAY: begin
        if (react_btn) begin
          state_d       = ST_FOUL;
          false_start_d = 1'b1;
        end else if (tick) begin
          if (ms_next == delay_target_q) begin
            state_d  = ST_MEASURE;
            ms_cnt_d = '0;
            tick_clr = 1'b1;
          end else begin
            ms_cnt_d = ms_next;
          end
        end
      end
      ST_MEASURE: begin
        if (react_btn) begin
          state_d        = ST_DONE;
          result_ms_d    = ms_cnt_q;
          result_valid_d = 1'b1;
          timeout_d      = 1'b0;
        end else if (tick) begin
          if (ms_next == MAX_RT) begin
            state_d        = ST_DONE;
            result_ms_d    = MAX_RT;
            result_valid_d = 1'b1;
            timeout_d      = 1'b1;
          end else begin
            ms_cnt_d = ms_next;
          end
        end
      end
      default: begin
        state_d        = ST_IDLE;
        ms_cnt_d       = '0;
        result_ms_d    = '0;
        result_valid_d = 1'b0;
        timeout_d      = 1'b0;
        false_start_d  = 1'b0;
      end
    endcase

    if (abort) begin
      state_d        = ST_IDLE;
      ms_cnt_d       = '0;
      result_ms_d    = '0;
      result_valid_d = 1'b0;
      timeout_d      = 1'b0;
      false_start_d  = 1'b0;
    end

    led_go_d = (state_d == ST_MEASURE);
    busy_d   = (state_d == ST_DELAY) || (state_d == ST_MEASURE);
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      lfsr_q         <= LFSR_SEED;
      ms_cnt_q       <= '0;
      delay_target_q <= '0;
      result_ms_q    <= '0;
      result_valid_q <= 1'b0;
      timeout_q      <= 1'b0;
      false_start_q  <= 1'b0;
      led_go_q       <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      lfsr_q         <= lfsr_d;
      ms_cnt_q       <= ms_cnt_d;
      delay_target_q <= delay_target_d;
      result_ms_q    <= result_ms_d;
      result_valid_q <= result_valid_d;
      timeout_q      <= timeout_d;
      false_start_q  <= false_start_d;
      led_go_q       <= led_go_d;
      busy_q         <= busy_d;
    end
  end

  assign led_go       = led_go_q;
  assign busy         = busy_q;
  assign result_ms    = result_ms_q;
  assign result_valid = result_valid_q;
  assign false_start  = false_start_q;
  assign timeout      = timeout_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_reaction_test_controller.sv
// Bench for reaction_test_controller: a fixed-delay and a randomised-delay instance
// share stimulus and are both checked every cycle against a cycle-count model.
module tb_reaction_test_controller;

  localparam int TD     = 10;
  localparam int MIN_MS = 5;
  localparam int MAX_MS = 50;
  localparam int RTW    = 14;

  // Trial model: phase 0..4 = idle/delay/measure/done/foul, elapsed = cycles since phase entry.
  typedef struct {
    int          phase;
    int          elapsed;
    int          target;
    int          result;
    bit          valid;
    bit          to;
    bit          fs;
    logic [15:0] lfsr;
  } mdl_t;

  logic sysclk = 1'b0;
  logic reset;
  logic start_btn;
  logic react_btn;
  logic abort;

  logic           go0, busy0, valid0, fs0, to0;
  logic [RTW-1:0] res0;
  logic [2:0]     st0;
  logic           gor, busyr, validr, fsr, tor;
  logic [RTW-1:0] resr;
  logic [2:0]     str;

  logic [RTW+7:0] v0;
  logic [RTW+7:0] vr;

  int compared   = 0;
  int mismatched = 0;
  bit chk_en     = 1'b0;

  mdl_t m0;
  mdl_t mr;

  always #5 sysclk = ~sysclk;

  reaction_test_controller #(
    .TICK_DIV(TD), .MIN_DELAY_MS(MIN_MS), .RAND_BITS(0), .MAX_RT_MS(MAX_MS), .RT_W(RTW)
  ) dut (
    .sysclk(sysclk), .reset(reset), .start_btn(start_btn), .react_btn(react_btn), .abort(abort),
    .led_go(go0), .busy(busy0), .result_ms(res0), .result_valid(valid0),
    .false_start(fs0), .timeout(to0), .state_o(st0)
  );

  reaction_test_controller #(
    .TICK_DIV(TD), .MIN_DELAY_MS(MIN_MS), .RAND_BITS(10), .MAX_RT_MS(MAX_MS), .RT_W(RTW)
  ) dut_r (
    .sysclk(sysclk), .reset(reset), .start_btn(start_btn), .react_btn(react_btn), .abort(abort),
    .led_go(gor), .busy(busyr), .result_ms(resr), .result_valid(validr),
    .false_start(fsr), .timeout(tor), .state_o(str)
  );

  assign v0 = {st0, go0, busy0, valid0, fs0, to0, res0};
  assign vr = {str, gor, busyr, validr, fsr, tor, resr};

  function automatic mdl_t model_init();
    mdl_t m;
    m.phase   = 0;
    m.elapsed = 0;
    m.target  = 0;
    m.result  = 0;
    m.valid   = 1'b0;
    m.to      = 1'b0;
    m.fs      = 1'b0;
    m.lfsr    = 16'hACE1;
    return m;
  endfunction

  function automatic mdl_t model_step(mdl_t m, bit st, bit rc, bit ab, int rb);
    mdl_t n;
    bit   fb;
    n = m;
    fb = m.lfsr[0] ^ m.lfsr[2] ^ m.lfsr[3] ^ m.lfsr[5];
    n.lfsr = {fb, m.lfsr[15:1]};
    n.elapsed = m.elapsed + 1;
    case (m.phase)
      1: begin
        if (rc) begin
          n.phase = 4; n.elapsed = 0; n.fs = 1'b1;
        end else if (m.elapsed == m.target * TD - 1) begin
          n.phase = 2; n.elapsed = 0;
        end
      end
      2: begin
        if (rc) begin
          n.phase = 3; n.elapsed = 0; n.valid = 1'b1; n.to = 1'b0; n.result = m.elapsed / TD;
        end else if (m.elapsed == MAX_MS * TD - 1) begin
          n.phase = 3; n.elapsed = 0; n.valid = 1'b1; n.to = 1'b1; n.result = MAX_MS;
        end
      end
      default: begin
        if (st) begin
          n.phase = 1; n.elapsed = 0; n.result = 0;
          n.valid = 1'b0; n.to = 1'b0; n.fs = 1'b0;
          n.target = MIN_MS + ((rb == 0) ? 0 : (int'(m.lfsr) % (1 << rb)));
        end
      end
    endcase
    if (ab) begin
      n.phase = 0; n.elapsed = 0; n.result = 0;
      n.valid = 1'b0; n.to = 1'b0; n.fs = 1'b0;
    end
    return n;
  endfunction

  function automatic logic [31:0] model_vec(mdl_t m);
    logic [RTW+7:0] v;
    v = {3'(m.phase), (m.phase == 2), (m.phase == 1) || (m.phase == 2),
         m.valid, m.fs, m.to, RTW'(m.result)};
    return 32'(v);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic applyStimulus(input bit st, input bit rc, input bit ab);
    start_btn = st;
    react_btn = rc;
    abort     = ab;
    @(negedge sysclk);
    start_btn = 1'b0;
    react_btn = 1'b0;
    abort     = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  // sel 0: fixed instance led_go, 1: fixed instance result_valid, 2: random instance led_go
  task automatic waitHigh(input int sel, input int bound, output int n);
    n = 0;
    while (n < bound) begin
      if (sel == 0 && go0 === 1'b1) break;
      if (sel == 1 && valid0 === 1'b1) break;
      if (sel == 2 && gor === 1'b1) break;
      @(negedge sysclk);
      n++;
    end
  endtask

  always @(posedge sysclk or posedge reset) begin
    if (reset) begin
      m0 <= model_init();
      mr <= model_init();
    end else begin
      m0 <= model_step(m0, start_btn, react_btn, abort, 0);
      mr <= model_step(mr, start_btn, react_btn, abort, 10);
    end
  end

  always @(negedge sysclk) begin
    if (chk_en) begin
      checkOutput("cyc_fixed", 32'(v0), model_vec(m0));
      checkOutput("cyc_rand", 32'(vr), model_vec(mr));
      checkOutput("lfsr_nonzero", 32'(dut_r.lfsr_q != 16'd0), 32'd1);
      checkOutput("lfsr_seq", 32'(dut_r.lfsr_q), 32'(mr.lfsr));
    end
  end

  initial begin
    int n;
    int fp[8];
    bit distinct;

    reset     = 1'b1;
    start_btn = 1'b0;
    react_btn = 1'b0;
    abort     = 1'b0;
    m0 = model_init();
    mr = model_init();
    idle(3);
    reset  = 1'b0;
    chk_en = 1'b1;
    checkOutput("reset_vec", 32'(v0), 32'd0);

    // Normal trial: 50-cycle foreperiod, reaction at measure cycle 123 -> 12 ms.
    applyStimulus(1, 0, 0);
    checkOutput("t1_busy", 32'(busy0), 32'd1);
    waitHigh(0, 200, n);
    checkOutput("t1_go_delay", 32'(n), 32'd50);
    idle(123);
    applyStimulus(0, 1, 0);
    checkOutput("t1_result", 32'(res0), 32'd12);
    checkOutput("t1_valid", 32'(valid0), 32'd1);
    checkOutput("t1_timeout", 32'(to0), 32'd0);

    // False start, then restart.
    applyStimulus(1, 0, 0);
    idle(19);
    applyStimulus(0, 1, 0);
    checkOutput("t2_false_start", 32'(fs0), 32'd1);
    checkOutput("t2_valid", 32'(valid0), 32'd0);
    idle(60);
    checkOutput("t2_go_low", 32'(go0), 32'd0);
    checkOutput("t2_fs_hold", 32'(fs0), 32'd1);
    applyStimulus(1, 0, 0);
    checkOutput("t2_fs_cleared", 32'(fs0), 32'd0);
    checkOutput("t2_state", 32'(st0), 32'd1);

    // Timeout after 500 measure cycles.
    waitHigh(0, 200, n);
    checkOutput("t3_go_delay", 32'(n), 32'd50);
    waitHigh(1, 1000, n);
    checkOutput("t3_timeout_cycles", 32'(n), 32'd500);
    checkOutput("t3_timeout", 32'(to0), 32'd1);
    checkOutput("t3_result", 32'(res0), 32'd50);
    checkOutput("t3_go_low", 32'(go0), 32'd0);

    // React on the delay-expiry cycle is a foul.
    applyStimulus(1, 0, 0);
    idle(49);
    applyStimulus(0, 1, 0);
    checkOutput("t4_expiry_foul", 32'(st0), 32'd4);
    checkOutput("t4_expiry_go", 32'(go0), 32'd0);

    // React on the ceiling tick wins, with a stray start in the middle.
    applyStimulus(1, 0, 0);
    waitHigh(0, 200, n);
    idle(100);
    applyStimulus(1, 0, 0);
    idle(398);
    applyStimulus(0, 1, 0);
    checkOutput("t4_ceiling_result", 32'(res0), 32'd49);
    checkOutput("t4_ceiling_timeout", 32'(to0), 32'd0);
    checkOutput("t4_ceiling_valid", 32'(valid0), 32'd1);

    // Asynchronous reset mid-cycle during measure.
    applyStimulus(1, 0, 0);
    waitHigh(0, 200, n);
    idle(20);
    #2 reset = 1'b1;
    #1;
    checkOutput("t5_async_fixed", 32'(v0), 32'd0);
    checkOutput("t5_async_rand", 32'(vr), 32'd0);
    #1 reset = 1'b0;
    @(negedge sysclk);

    // Abort during delay.
    applyStimulus(1, 0, 0);
    idle(10);
    applyStimulus(0, 0, 1);
    checkOutput("t5_abort_state", 32'(st0), 32'd0);
    checkOutput("t5_abort_busy", 32'(busy0), 32'd0);

    // Random traffic checked cycle by cycle.
    repeat (4000) begin
      start_btn = ($urandom_range(0, 99) < 2);
      react_btn = ($urandom_range(0, 99) < 2);
      abort     = ($urandom_range(0, 499) == 0);
      @(negedge sysclk);
    end
    start_btn = 1'b0;
    react_btn = 1'b0;
    abort     = 1'b0;

    // Randomised foreperiods over eight trials.
    applyStimulus(0, 0, 1);
    for (int t = 0; t < 8; t++) begin
      idle($urandom_range(1, 20));
      applyStimulus(1, 0, 0);
      waitHigh(2, 1100 * TD, n);
      fp[t] = n / TD;
      checkOutput("t6_range", 32'((fp[t] >= 5) && (fp[t] <= 1028) && (n % TD == 0)), 32'd1);
      applyStimulus(0, 1, 0);
    end
    distinct = 1'b0;
    for (int t = 1; t < 8; t++) begin
      if (fp[t] != fp[0]) distinct = 1'b1;
    end
    checkOutput("t6_not_all_equal", 32'(distinct), 32'd1);

    idle(2);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/reaction_test_controller.md
Name: reaction_test_controller

Overview:
Top-level sequencer for the reaction speed tester. After a start press it waits a pseudo-random foreperiod, lights the GO indicator, then measures the time to the reaction press in whole milliseconds. It detects false starts (press before GO) and timeouts. It replaces the fixed one-second start delay with a programmable, randomised one, and it feeds the result and status to the display and LED logic.

Parameters:
TICK_DIV, 100000, sysclk cycles per 1 ms tick (100 MHz clock); benches use small values
MIN_DELAY_MS, 1000, fixed part of the foreperiod in ms
RAND_BITS, 10, width of the random foreperiod addend (0..2^RAND_BITS-1 ms); 0 disables randomisation
MAX_RT_MS, 9999, measurement ceiling in ms; reaching it declares a timeout
RT_W, 14, width of result_ms and internal ms counters; must hold max(MAX_RT_MS, MIN_DELAY_MS+2^RAND_BITS-1)

Ports:
sysclk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start_btn  in  1  single-cycle pulse, debounced upstream; starts a trial
react_btn  in  1  single-cycle pulse, debounced upstream; player reaction
abort  in  1  synchronous return to IDLE; clears result and status
led_go  out  1  GO indicator; high only in MEASURE
busy  out  1  high in DELAY or MEASURE
result_ms  out  RT_W  measured reaction time in ms; valid when result_valid=1
result_valid  out  1  high in DONE, including the timeout case
false_start  out  1  high in FOUL
timeout  out  1  high in DONE when the ceiling was reached
state_o  out  3  current state encoding, for debug and display

Behaviour:
- All outputs and registers are registered. Reset is asynchronous: asserting reset forces, immediately, state=IDLE and all outputs, counters and the prescaler to 0. The LFSR loads 16'hACE1.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. It advances every cycle, including in IDLE, and is never zero. The foreperiod is delay_target = MIN_DELAY_MS + lfsr[RAND_BITS-1:0], latched on the start_btn cycle.
- ms tick: a prescaler counts 0..TICK_DIV-1, and tick=1 in the cycle where it equals TICK_DIV-1. The prescaler clears on every entry into DELAY and MEASURE, so the first tick occurs TICK_DIV cycles after entry.
- States:
  IDLE(0): start_btn -> DELAY; ms_cnt cleared.
  DELAY(1):
  - ms_cnt increments on tick.
  - react_btn -> FOUL.
  - tick with ms_cnt==delay_target-1 -> MEASURE, with ms_cnt cleared.
  - If react_btn and the expiry coincide, FOUL wins.
  MEASURE(2):
  - led_go=1 from the first cycle in this state; ms_cnt increments on tick.
  - react_btn -> DONE, result_ms=ms_cnt (value before any same-cycle increment). This is floor(elapsed cycles/TICK_DIV).
  - tick with ms_cnt==MAX_RT_MS-1 -> DONE, timeout=1, result_ms=MAX_RT_MS.
  - If react and the ceiling coincide, react wins: timeout=0, result_ms=MAX_RT_MS-1.
  DONE(3): outputs hold; start_btn -> DELAY, clearing result_valid, timeout and result_ms.
  FOUL(4): false_start=1 and holds; start_btn -> DELAY, clearing false_start.
- start_btn is ignored in DELAY and MEASURE. react_btn is ignored in IDLE, DONE and FOUL.
- abort has priority over every transition: next state IDLE, all status outputs cleared.
- Encodings 5-7 are unreachable; the FSM recovers to IDLE from them on the next clock.
- ms_cnt never wraps: it is bounded by delay_target and MAX_RT_MS.

Decomposition:
- Shared package reaction_pkg holds:
  - the state enum/localparams (IDLE..FOUL, 3-bit);
  - the LFSR seed and tap mask;
  - the default TICK_DIV.
- One natural sub-module: ms_tick_gen (prescaler with sync clear input and tick output).
- The FSM, LFSR and ms counter stay in the top module.

Test Plan:
All scenarios use TICK_DIV=10, MIN_DELAY_MS=5, RAND_BITS=0, MAX_RT_MS=50.
1. start_btn pulse -> busy=1 next cycle; led_go rises exactly 50 cycles after DELAY entry. react_btn 123 cycles after led_go rises -> DONE, result_ms=12, result_valid=1, timeout=0.
2. start_btn, then react_btn 20 cycles later -> false_start=1, led_go stays 0, result_valid=0. A further start_btn clears false_start and re-enters DELAY.
3. start_btn with no reaction -> 500 cycles after led_go rises: timeout=1, result_valid=1, result_ms=50, led_go=0.
4. react_btn on the cycle DELAY expires -> FOUL. react_btn on the ceiling tick -> result_ms=49, timeout=0. start_btn during MEASURE -> no effect on the timing of the result.
5. reset pulsed asynchronously, mid-cycle, during MEASURE -> every output 0 before the next clock edge, state_o=0. abort in DELAY -> IDLE next cycle.
6. RAND_BITS=10, 8 consecutive trials -> all foreperiods lie in 5..1028 ms and are not all equal; the LFSR never reads 0.
